agc_loop_ctrl: RTL and testbench

//  Closed-loop sequencer for one agc_core instance, in the aclk domain. Runs the measure/update cycle in hardware:

---
 rtl/agc_loop_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_agc_loop_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/agc_loop_ctrl.sv
// Hardware measure/update sequencer for one agc_core: tick, accumulate INTERVAL cycles, flush, compute, load, apply.
// Iteration latency is INTERVAL+FLUSH_CYCLES+4 cycles (one less on hold); no backpressure, enable_i low aborts measurement.
module agc_loop_ctrl #(
  parameter int          INTERVAL     = 131072,
  parameter int          FLUSH_CYCLES = 6,
  parameter logic [24:0] TARGET_SQ    = 25'h0400000,
  parameter int          GAIN_SHIFT   = 8,
  parameter int          OFS_SHIFT    = 4,
  parameter logic [16:0] SCALE_MIN    = 17'h00100,
  parameter logic [16:0] SCALE_MAX    = 17'h1FFFF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable_i,
  input  logic        hold_i,
  input  logic [16:0] init_scale_i,
  input  logic [15:0] init_offset_i,
  input  logic [24:0] sq_accum_i,
  input  logic [20:0] gt_accum_i,
  input  logic [20:0] lt_accum_i,
  output logic        agc_rst_o,
  output logic        agc_tick_o,
  output logic        agc_ce_o,
  output logic [16:0] agc_scale_o,
  output logic [15:0] agc_offset_o,
  output logic        agc_scale_ce_o,
  output logic        agc_offset_ce_o,
  output logic        agc_apply_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  sat_o,
  output logic [15:0] iter_count_o
);

  localparam int CNT_MAX = (INTERVAL > FLUSH_CYCLES) ? INTERVAL : FLUSH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] ACC_LAST   = CW'(INTERVAL - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
  localparam logic signed [26:0] S_MIN = $signed({10'd0, SCALE_MIN});
  localparam logic signed [26:0] S_MAX = $signed({10'd0, SCALE_MAX});
  localparam logic signed [22:0] O_MIN = -23'sd32768;
  localparam logic signed [22:0] O_MAX = 23'sd32767;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INITAP, S_TICK, S_ACCUM, S_FLUSH, S_CALC, S_UPDATE, S_APPLY
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic signed [25:0] err, err_sh;
  logic signed [21:0] diff, diff_sh;
  logic signed [26:0] s_sum;
  logic signed [22:0] o_sum;
  logic [16:0]        scale_nxt;
  logic [15:0]        offset_nxt;
  logic               s_clamp, o_clamp;

  // Sums are widened so the clamp comparisons see the true signed result.
  always_comb begin
    err     = $signed({1'b0, TARGET_SQ}) - $signed({1'b0, sq_accum_i});
    diff    = $signed({1'b0, gt_accum_i}) - $signed({1'b0, lt_accum_i});
    err_sh  = err >>> GAIN_SHIFT;
    diff_sh = diff >>> OFS_SHIFT;
    s_sum   = $signed({10'd0, agc_scale_o}) + $signed({err_sh[25], err_sh});
    o_sum   = $signed({{7{agc_offset_o[15]}}, agc_offset_o}) - $signed({diff_sh[21], diff_sh});
    scale_nxt  = s_sum[16:0];
    s_clamp    = 1'b0;
    offset_nxt = o_sum[15:0];
    o_clamp    = 1'b0;
    if (s_sum < S_MIN) begin
      scale_nxt = SCALE_MIN;
      s_clamp   = 1'b1;
    end else if (s_sum > S_MAX) begin
      scale_nxt = SCALE_MAX;
      s_clamp   = 1'b1;
    end
    if (o_sum < O_MIN) begin
      offset_nxt = 16'h8000;
      o_clamp    = 1'b1;
    end else if (o_sum > O_MAX) begin
      offset_nxt = 16'h7FFF;
      o_clamp    = 1'b1;
    end
  end

  assign busy_o = (state != S_IDLE);

  // Pulse outputs are set on the transition into their state so they align with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      agc_rst_o       <= 1'b0;
      agc_tick_o      <= 1'b0;
      agc_ce_o        <= 1'b0;
      agc_scale_o     <= '0;
      agc_offset_o    <= '0;
      agc_scale_ce_o  <= 1'b0;
      agc_offset_ce_o <= 1'b0;
      agc_apply_o     <= 1'b0;
      done_o          <= 1'b0;
      sat_o           <= '0;
      iter_count_o    <= '0;
    end else begin
      agc_rst_o       <= 1'b0;
      agc_tick_o      <= 1'b0;
      agc_scale_ce_o  <= 1'b0;
      agc_offset_ce_o <= 1'b0;
      agc_apply_o     <= 1'b0;
      done_o          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            agc_scale_o     <= init_scale_i;
            agc_offset_o    <= init_offset_i;
            sat_o           <= '0;
            iter_count_o    <= '0;
            agc_rst_o       <= 1'b1;
            agc_scale_ce_o  <= 1'b1;
            agc_offset_ce_o <= 1'b1;
            state           <= S_INIT;
          end
        end
        S_INIT: begin
          agc_apply_o <= 1'b1;
          state       <= S_INITAP;
        end
        S_INITAP: begin
          agc_tick_o <= 1'b1;
          state      <= S_TICK;
        end
        S_TICK: begin
          cnt <= '0;
          if (!enable_i) begin
            state <= S_IDLE;
          end else begin
            agc_ce_o <= 1'b1;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!enable_i) begin
            agc_ce_o <= 1'b0;
            cnt      <= '0;
            state    <= S_IDLE;
          end else if (cnt == ACC_LAST) begin
            agc_ce_o <= 1'b0;
            cnt      <= '0;
            state    <= S_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (!enable_i) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == FLUSH_LAST) begin
            cnt   <= '0;
            state <= S_CALC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CALC: begin
          if (hold_i) begin
            done_o       <= 1'b1;
            iter_count_o <= iter_count_o + 1'b1;
            state        <= S_APPLY;
          end else begin
            agc_scale_o     <= scale_nxt;
            agc_offset_o    <= offset_nxt;
            sat_o           <= sat_o | {o_clamp, s_clamp};
            agc_scale_ce_o  <= 1'b1;
            agc_offset_ce_o <= 1'b1;
            state           <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          agc_apply_o  <= 1'b1;
          done_o       <= 1'b1;
          iter_count_o <= iter_count_o + 1'b1;
          state        <= S_APPLY;
        end
        S_APPLY: begin
          if (enable_i) begin
            agc_tick_o <= 1'b1;
            state      <= S_TICK;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Bench for agc_loop_ctrl: table of per-iteration accumulator values and expected results, scoreboarded on done_o.
module tb_agc_loop_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable_i = 1'b0;
  logic        hold_i = 1'b0;
  logic [16:0] init_scale_i = '0;
  logic [15:0] init_offset_i = '0;
  logic [24:0] sq_accum_i = '0;
  logic [20:0] gt_accum_i = '0;
  logic [20:0] lt_accum_i = '0;
  logic        agc_rst_o, agc_tick_o, agc_ce_o;
  logic [16:0] agc_scale_o;
  logic [15:0] agc_offset_o;
  logic        agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, busy_o, done_o;
  logic [1:0]  sat_o;
  logic [15:0] iter_count_o;

  agc_loop_ctrl #(
    .INTERVAL(16), .FLUSH_CYCLES(6), .GAIN_SHIFT(4), .OFS_SHIFT(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(enable_i), .hold_i(hold_i),
    .init_scale_i(init_scale_i), .init_offset_i(init_offset_i),
    .sq_accum_i(sq_accum_i), .gt_accum_i(gt_accum_i), .lt_accum_i(lt_accum_i),
    .agc_rst_o(agc_rst_o), .agc_tick_o(agc_tick_o), .agc_ce_o(agc_ce_o),
    .agc_scale_o(agc_scale_o), .agc_offset_o(agc_offset_o),
    .agc_scale_ce_o(agc_scale_ce_o), .agc_offset_ce_o(agc_offset_ce_o),
    .agc_apply_o(agc_apply_o), .busy_o(busy_o), .done_o(done_o),
    .sat_o(sat_o), .iter_count_o(iter_count_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        hold;
    logic [24:0] sq;
    logic [20:0] gt;
    logic [20:0] lt;
    logic [16:0] scale;
    logic [15:0] offset;
    logic [1:0]  sat;
  } vec_t;

  typedef struct {
    logic [16:0] scale;
    logic [15:0] offset;
    logic [1:0]  sat;
    logic [15:0] iter;
    logic        hold;
  } exp_t;

  vec_t vec[7];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  wire [58:0] all_out = {agc_rst_o, agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o,
                         agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, busy_o, done_o,
                         sat_o, iter_count_o};
  wire [4:0] pulses = {agc_rst_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, done_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v, input int iter);
    exp_t e;
    hold_i     = v.hold;
    sq_accum_i = v.sq;
    gt_accum_i = v.gt;
    lt_accum_i = v.lt;
    e.scale  = v.scale;
    e.offset = v.offset;
    e.sat    = v.sat;
    e.iter   = 16'(iter);
    e.hold   = v.hold;
    sbq.push_back(e);
  endtask

  // Entered on the negedge of the TICK cycle; returns on the negedge of the APPLY cycle.
  task automatic run_iter(input string tag);
    int   cyc, nce, nsce, noce, nap;
    bit   got;
    exp_t e;
    cyc = 0; nce = 0; nsce = 0; noce = 0; nap = 0; got = 1'b0;
    chk({tag, "_tick"}, 64'(agc_tick_o), 64'd1);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge aclk);
      cyc++;
      nce  += int'(agc_ce_o);
      nsce += int'(agc_scale_ce_o);
      noce += int'(agc_offset_ce_o);
      nap  += int'(agc_apply_o);
      if (done_o) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no done_o within 200 cycles", tag);
    end
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_scoreboard: expected queue empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_ce_cycles"}, 64'(nce), 64'd16);
      chk({tag, "_done_lat"}, 64'(cyc), e.hold ? 64'd24 : 64'd25);
      chk({tag, "_scale_ce"}, 64'(nsce), e.hold ? 64'd0 : 64'd1);
      chk({tag, "_offset_ce"}, 64'(noce), e.hold ? 64'd0 : 64'd1);
      chk({tag, "_apply"}, 64'(nap), e.hold ? 64'd0 : 64'd1);
      chk({tag, "_scale"}, 64'(agc_scale_o), 64'(e.scale));
      chk({tag, "_offset"}, 64'(agc_offset_o), 64'(e.offset));
      chk({tag, "_sat"}, 64'(sat_o), 64'(e.sat));
      chk({tag, "_iter"}, 64'(iter_count_o), 64'(e.iter));
    end
  endtask

  task automatic check_start(input string tag, input logic [16:0] s, input logic [15:0] o);
    @(negedge aclk);
    chk({tag, "_init_pulses"}, 64'({agc_rst_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, agc_tick_o}), 64'b11100);
    chk({tag, "_init_state"}, 64'({busy_o, agc_scale_o, agc_offset_o, sat_o, iter_count_o}), 64'({1'b1, s, o, 2'b00, 16'h0}));
    @(negedge aclk);
    chk({tag, "_initap_pulses"}, 64'({agc_rst_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, agc_tick_o}), 64'b00010);
    @(negedge aclk);
  endtask

  initial begin
    vec_t v;
    // hold, sq, gt, lt -> scale, offset, sat (INTERVAL=16, GAIN_SHIFT=4, OFS_SHIFT=2, start 0x01000/0)
    vec[0] = '{1'b0, 25'h03FC000, 21'd100,    21'd100,  17'h01400, 16'h0000, 2'b00};
    vec[1] = '{1'b0, 25'h0408000, 21'd1000,   21'd200,  17'h00C00, 16'hFF38, 2'b00};
    vec[2] = '{1'b1, 25'h0000000, 21'd0,      21'd5000, 17'h00C00, 16'hFF38, 2'b00};
    vec[3] = '{1'b0, 25'h1FFFFFF, 21'd0,      21'd0,    17'h00100, 16'hFF38, 2'b01};
    vec[4] = '{1'b0, 25'h0400000, 21'd200000, 21'd0,    17'h00100, 16'h8000, 2'b11};
    vec[5] = '{1'b0, 25'h0000000, 21'd0,      21'd2000, 17'h1FFFF, 16'h81F4, 2'b11};
    vec[6] = '{1'b0, 25'h0412345, 21'd0,      21'd7,    17'h1EDCA, 16'h81F6, 2'b11};

    // Reset, idle with enable low
    #12 aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      chk("idle_outputs", 64'(all_out), 64'd0);
    end

    // Startup pulses followed by the table-driven iterations
    init_scale_i  = 17'h01000;
    init_offset_i = 16'h0000;
    drive_vec(vec[0], 1);
    enable_i = 1'b1;
    check_start("start", 17'h01000, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      run_iter($sformatf("iter%0d", i));
      if (i < 6) drive_vec(vec[i + 1], i + 2);
      @(negedge aclk);
    end

    // Abort in ACCUM cycle 5
    repeat (5) @(negedge aclk);
    chk("abort_pre_ce", 64'(agc_ce_o), 64'd1);
    enable_i = 1'b0;
    @(negedge aclk);
    chk("abort_ce_busy", 64'({agc_ce_o, busy_o}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk("abort_quiet", 64'({pulses, agc_ce_o, agc_tick_o, busy_o}), 64'd0);
    end

    // Re-enable restarts from INIT with fresh init values
    init_scale_i  = 17'h02000;
    init_offset_i = 16'h0010;
    v = '{1'b0, 25'h0400000, 21'd0, 21'd0, 17'h02000, 16'h0010, 2'b00};
    drive_vec(v, 1);
    enable_i = 1'b1;
    check_start("restart", 17'h02000, 16'h0010);
    run_iter("restart_iter");

    // Asynchronous reset in the middle of ACCUM
    repeat (4) @(negedge aclk);
    chk("arst_pre_ce", 64'(agc_ce_o), 64'd1);
    #2 aresetn = 1'b0;
    #1 chk("arst_outputs", 64'(all_out), 64'd0);
    enable_i = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("arst_idle", 64'(all_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
